// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared constants and FSM encoding for the parity scheduler
package parity_pkg;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int ERR_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    RESULT = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational 4-way round-robin pick starting after last_id
module rr_arbiter (
  input  logic [3:0] req,
  input  logic [1:0] last_id,
  output logic       valid,
  output logic [1:0] id
);
  logic [1:0] cand;

  always_comb begin
    valid = |req;
    id    = last_id;
    cand  = last_id;
    // Walk from farthest to nearest so the nearest requester after last_id wins
    for (int k = 3; k >= 1; k--) begin
      cand = last_id + 2'(k);
      if (req[cand]) id = cand;
    end
  end
endmodule

// File: rtl/parity_sched.sv
// rtl/parity_sched.sv - round-robin shared parity unit; PARITY_ERRCHK_EN adds expected-parity checking
module parity_sched
  import parity_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  input  logic                  oddMode,
`ifdef PARITY_ERRCHK_EN
  input  logic [NREQ-1:0]       expPar,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic                  done,
  output logic [1:0]            doneId,
  output logic                  parity,
  output logic                  busy,
`ifdef PARITY_ERRCHK_EN
  output logic [ERR_W-1:0]      errCount,
`endif
  output logic                  ledR,
  output logic                  ledG,
  output logic                  ledB
);
  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_reg;
  logic [1:0]       id_reg;
  logic [1:0]       last_id;
  logic             pick_valid;
  logic [1:0]       pick_id;

  rr_arbiter u_arb (
    .req     (req),
    .last_id (last_id),
    .valid   (pick_valid),
    .id      (pick_id)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = CALC;
      CALC:    state_nxt = RESULT;
      RESULT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      gnt     <= '0;
      op_reg  <= '0;
      id_reg  <= '0;
      last_id <= 2'd3;
      doneId  <= '0;
      parity  <= 1'b0;
    end else begin
      gnt <= '0;
      if (state == IDLE && pick_valid) begin
        gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << pick_id;
        op_reg <= data[WIDTH*pick_id +: WIDTH];
        id_reg <= pick_id;
      end
      if (state == CALC) begin
        parity  <= (^op_reg) ^ oddMode;
        last_id <= id_reg;
        doneId  <= id_reg;
      end
    end
  end

  assign done = (state == RESULT);
  assign busy = (state != IDLE);
  assign ledG = busy;
  assign ledB = parity;

`ifdef PARITY_ERRCHK_EN
  logic exp_reg;
  logic err_sticky;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      exp_reg    <= 1'b0;
      errCount   <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (state == IDLE && pick_valid) exp_reg <= expPar[pick_id];
      if (state == RESULT && parity != exp_reg) begin
        if (errCount != {ERR_W{1'b1}}) errCount <= errCount + 1'b1;
        err_sticky <= 1'b1;
      end
    end
  end

  assign ledR = err_sticky;
`else
  assign ledR = 1'b0;
`endif
endmodule

// File: tb/tb_parity_sched.sv
// tb/tb_parity_sched.sv - directed bench with a cycle-timeline model of parity_sched
module tb_parity_sched;
  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [3:0]  req = 4'd0;
  logic [15:0] data = 16'd0;
  logic        oddMode = 1'b0;
  logic [3:0]  expPar = 4'd0;
  logic [3:0]  gnt;
  logic        done, parity, busy, ledR, ledG, ledB;
  logic [1:0]  doneId;
  logic [7:0]  errCount;

  int vectors = 0;
  int miscompares = 0;

  parity_sched dut (
    .clk      (clk),
    .resetN   (resetN),
    .req      (req),
    .data     (data),
    .oddMode  (oddMode),
`ifdef PARITY_ERRCHK_EN
    .expPar   (expPar),
`endif
    .gnt      (gnt),
    .done     (done),
    .doneId   (doneId),
    .parity   (parity),
    .busy     (busy),
`ifdef PARITY_ERRCHK_EN
    .errCount (errCount),
`endif
    .ledR     (ledR),
    .ledG     (ledG),
    .ledB     (ledB)
  );

`ifndef PARITY_ERRCHK_EN
  assign errCount = 8'd0;
`endif

  always #5 clk = ~clk;

  // Timeline model: an operation granted at edge g shows gnt after g, done after g+1,
  // and the next request can only be taken at edge g+3.
  int         e = 0;
  int         g_edge = -100;
  int         m_last = 3;
  int         m_w = 0;
  logic [3:0] m_word = 4'd0;
  logic       m_expbit = 1'b0;
  logic [3:0] m_gnt = 4'd0;
  logic       m_done = 1'b0, m_busy = 1'b0, m_par = 1'b0, m_sticky = 1'b0;
  int         m_id = 0;
  int         m_err = 0;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      g_edge = -100; m_last = 3; m_gnt = 4'd0; m_done = 1'b0; m_busy = 1'b0;
      m_par = 1'b0; m_id = 0; m_err = 0; m_sticky = 1'b0;
    end else begin
      e = e + 1;
`ifdef PARITY_ERRCHK_EN
      if (e == g_edge + 2 && m_par != m_expbit) begin
        if (m_err < 255) m_err = m_err + 1;
        m_sticky = 1'b1;
      end
`endif
      if (e == g_edge + 1) begin
        m_par = (m_word[0] ^ m_word[1] ^ m_word[2] ^ m_word[3]) ^ oddMode;
        m_id  = m_w;
      end
      if (e >= g_edge + 3 && req != 4'd0) begin
        bit found;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_last + k) % 4;
          if (!found && req[c]) begin
            found = 1'b1;
            m_w = c;
          end
        end
        g_edge   = e;
        m_last   = m_w;
        m_word   = data[m_w*4 +: 4];
        m_expbit = expPar[m_w];
      end
      m_gnt  = (e == g_edge) ? (4'd1 << m_w) : 4'd0;
      m_done = (e == g_edge + 1);
      m_busy = (e == g_edge) || (e == g_edge + 1);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("gnt", 32'(gnt), 32'(m_gnt));
    check("done", 32'(done), 32'(m_done));
    check("busy", 32'(busy), 32'(m_busy));
    check("doneId", 32'(doneId), 32'(m_id));
    check("parity", 32'(parity), 32'(m_par));
    check("ledR", 32'(ledR), 32'(m_sticky));
    check("ledG", 32'(ledG), 32'(m_busy));
    check("ledB", 32'(ledB), 32'(m_par));
    check("errCount", 32'(errCount), 32'(m_err));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    req = 4'd0;
    tick(2);
    resetN = 1'b1;
  endtask

  logic [3:0] gq[$];

  task automatic collect(input int n);
    repeat (n) begin
      @(negedge clk);
      if (gnt != 4'd0) gq.push_back(gnt);
    end
  endtask

  initial begin
    tick(1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ledR", 32'(ledR), 32'd0);
    do_reset();

    // Single request from requester 0: 1011 has three ones -> even parity 1
    req = 4'b0001; data = 16'h000B; oddMode = 1'b0;
    tick(1);
    check("t1_gnt", 32'(gnt), 32'h1);
    req = 4'd0;
    tick(1);
    check("t1_done", 32'(done), 32'd1);
    check("t1_doneId", 32'(doneId), 32'd0);
    check("t1_parity", 32'(parity), 32'd1);
    check("t1_ledB", 32'(ledB), 32'd1);
    check("t1_nognt", 32'(gnt), 32'd0);
    tick(2);

    // All requesting: rotation 0,1,2,3,0 with odd parity of zero words
    do_reset();
    gq.delete();
    req = 4'b1111; data = 16'h0000; oddMode = 1'b1;
    collect(15);
    req = 4'd0;
    check("t2_count", 32'(gq.size()), 32'd5);
    if (gq.size() >= 5) begin
      check("t2_g0", 32'(gq[0]), 32'h1);
      check("t2_g1", 32'(gq[1]), 32'h2);
      check("t2_g2", 32'(gq[2]), 32'h4);
      check("t2_g3", 32'(gq[3]), 32'h8);
      check("t2_g4", 32'(gq[4]), 32'h1);
    end
    check("t2_parity", 32'(parity), 32'd1);
    tick(3);

    // Serve requester 2, then 0101 must wrap to 0 before 2
    do_reset();
    req = 4'b0100; data = 16'h0F00; oddMode = 1'b0;
    tick(1);
    check("t3_first", 32'(gnt), 32'h4);
    req = 4'd0;
    tick(2);
    gq.delete();
    req = 4'b0101;
    collect(6);
    req = 4'd0;
    check("t3_count", 32'(gq.size()), 32'd2);
    if (gq.size() >= 2) begin
      check("t3_g0", 32'(gq[0]), 32'h1);
      check("t3_g1", 32'(gq[1]), 32'h4);
    end
    tick(3);

    // Reset while in CALC drops the operation
    do_reset();
    req = 4'b0010; data = 16'h0010;
    tick(1);
    check("t4_gnt", 32'(gnt), 32'h2);
    req = 4'd0;
    #2 resetN = 1'b0;
    #1;
    check("t4_rst_gnt", 32'(gnt), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_done", 32'(done), 32'd0);
    tick(1);
    resetN = 1'b1;
    tick(3);
    req = 4'b0011;
    tick(1);
    check("t4_after", 32'(gnt), 32'h1);
    req = 4'd0;
    tick(3);

    // Requester 1 word 0111 with expected parity 0: a mismatch when checking is built in
    do_reset();
    req = 4'b0010; data = 16'h0070; oddMode = 1'b0; expPar = 4'b0000;
    tick(1);
    req = 4'd0;
    tick(1);
    check("t5_done", 32'(done), 32'd1);
    check("t5_parity", 32'(parity), 32'd1);
    check("t5_doneId", 32'(doneId), 32'd1);
    tick(1);
`ifdef PARITY_ERRCHK_EN
    check("t5_err1", 32'(errCount), 32'd1);
    check("t5_ledR", 32'(ledR), 32'd1);
    req = 4'b0010;
    tick(3 * 262);
    req = 4'd0;
    tick(3);
    check("t5_sat", 32'(errCount), 32'd255);
    check("t5_ledR_hold", 32'(ledR), 32'd1);
`else
    check("t5_ledR", 32'(ledR), 32'd0);
    tick(3);
    check("t5_ledR_hold", 32'(ledR), 32'd0);
`endif
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
